// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS pipeline memory stage.
// Takes the EX/MEM pipeline register and produces the MEM/WB pipeline register.
// It contains a word-addressed data memory whose accesses take MEM_LATENCY cycles.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   EXMEMReg - [31:0] ALU result/address, [63:32] store data, [68:64] rd,
//              [69] zero, [70] overflow, [71] MemRead, [72] MemToReg,
//              [73] MemWrite, [74] RegWrite
//   MEMWBReg - [31:0] result, [36:32] rd, [37] RegWrite (registered)
//   memStall - high while an access is in flight; upstream holds EXMEMReg
//   memFault - one-cycle pulse for an illegal memory request
module mem_access_stage #(
   parameter int MEM_DEPTH   = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [74:0] EXMEMReg,
   output logic [37:0] MEMWBReg,
   output logic        memStall,
   output logic        memFault
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CW = $clog2(MEM_LATENCY) + 1;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [37:0]    wb_q, wb_d;
   logic           stall_q, stall_d;
   logic           fault_q, fault_d;

   // Operation latched for a multi-cycle access
   logic [AW-1:0]  lat_idx_q;
   logic [31:0]    lat_data_q, lat_alu_q;
   logic [4:0]     lat_rd_q;
   logic           lat_m2r_q, lat_rw_q, lat_mw_q;
   logic           lat_en_s;

   logic [31:0]    mem_q [MEM_DEPTH];

   // Field decode of the incoming EX/MEM register
   logic [31:0]    alu_s, sdata_s;
   logic [29:0]    in_idx_s;
   logic [4:0]     rd_s;
   logic           ovf_s, mr_s, m2r_s, mw_s, rw_s;
   logic           legal_s, memop_s;
   logic           unused_zero_s;

   logic [AW-1:0]  acc_idx_s;
   logic [31:0]    rd_data_s;
   logic           mem_we_s;
   logic [31:0]    mem_wdata_s;

   assign alu_s         = EXMEMReg[31:0];
   assign sdata_s       = EXMEMReg[63:32];
   assign rd_s          = EXMEMReg[68:64];
   assign unused_zero_s = EXMEMReg[69];
   assign ovf_s         = EXMEMReg[70];
   assign mr_s          = EXMEMReg[71];
   assign m2r_s         = EXMEMReg[72];
   assign mw_s          = EXMEMReg[73];
   assign rw_s          = EXMEMReg[74];
   assign in_idx_s      = EXMEMReg[31:2];
   assign memop_s       = mr_s | mw_s;
   assign legal_s       = (alu_s[1:0] == 2'b00) &&
                          ({2'b00, in_idx_s} < 32'(MEM_DEPTH)) &&
                          !(mr_s && mw_s);

   // The address used by the memory is the latched one while an access is in flight
   assign acc_idx_s = (state_q == ACCESS) ? lat_idx_q : in_idx_s[AW-1:0];
   assign rd_data_s = mem_q[acc_idx_s];

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wb_d        = wb_q;
      stall_d     = 1'b0;
      fault_d     = 1'b0;
      lat_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_wdata_s = sdata_s;
      case (state_q)
         IDLE: begin
            if (ovf_s) begin
               // Squashed instruction: no access, no fault
               wb_d = {1'b0, rd_s, alu_s};
            end else if (!memop_s) begin
               wb_d = {rw_s, rd_s, alu_s};
            end else if (!legal_s) begin
               wb_d    = {1'b0, rd_s, alu_s};
               fault_d = 1'b1;
            end else if (MEM_LATENCY == 1) begin
               // Load returns pre-write contents of the addressed word
               mem_we_s    = mw_s;
               mem_wdata_s = sdata_s;
               wb_d        = {rw_s, rd_s, m2r_s ? rd_data_s : alu_s};
            end else begin
               // Bubble: forwarding must not see a register write while stalled
               lat_en_s = 1'b1;
               cnt_d    = CW'(MEM_LATENCY - 1);
               state_d  = ACCESS;
               stall_d  = 1'b1;
               wb_d     = {1'b0, wb_q[36:0]};
            end
         end
         ACCESS: begin
            if (cnt_q <= CW'(1)) begin
               mem_we_s    = lat_mw_q;
               mem_wdata_s = lat_data_q;
               wb_d        = {lat_rw_q, lat_rd_q, lat_m2r_q ? rd_data_s : lat_alu_q};
               cnt_d       = '0;
               state_d     = IDLE;
               stall_d     = 1'b0;
            end else begin
               cnt_d   = cnt_q - CW'(1);
               stall_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Control state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wb_q    <= '0;
         stall_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wb_q    <= wb_d;
         stall_q <= stall_d;
         fault_q <= fault_d;
      end
   end

   // Capture of the operation for a multi-cycle access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_idx_q  <= '0;
         lat_data_q <= '0;
         lat_alu_q  <= '0;
         lat_rd_q   <= '0;
         lat_m2r_q  <= 1'b0;
         lat_rw_q   <= 1'b0;
         lat_mw_q   <= 1'b0;
      end else if (lat_en_s) begin
         lat_idx_q  <= in_idx_s[AW-1:0];
         lat_data_q <= sdata_s;
         lat_alu_q  <= alu_s;
         lat_rd_q   <= rd_s;
         lat_m2r_q  <= m2r_s;
         lat_rw_q   <= rw_s;
         lat_mw_q   <= mw_s;
      end
   end

   // Data memory array; contents survive reset, and no write commits while reset is held
   always_ff @(posedge clk) begin
      if (mem_we_s && rst_n) begin
         mem_q[acc_idx_s] <= mem_wdata_s;
      end
   end

   assign MEMWBReg = wb_q;
   assign memStall = stall_q;
   assign memFault = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: one instance with MEM_LATENCY=2 and one with MEM_LATENCY=3.
// Both share the clock and reset. A transaction-level model predicts the result, stall
// length and fault of every operation.
module tb_mem_access_stage;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [74:0] ex2, ex3;
   logic [37:0] wb2, wb3;
   logic        st2, st3, ft2, ft3;

   always #5 clk = ~clk;

   mem_access_stage #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .EXMEMReg(ex2),
      .MEMWBReg(wb2), .memStall(st2), .memFault(ft2));

   mem_access_stage #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .EXMEMReg(ex3),
      .MEMWBReg(wb3), .memStall(st3), .memFault(ft3));

   int checks = 0;
   int failures = 0;

   // Reference state: memory image and last MEM/WB value per instance (0: L=2, 1: L=3)
   logic [31:0] mdl [2][DEPTH];
   logic [37:0] last_wb [2];

   task automatic chk38(input string tag, input logic [37:0] obs, input logic [37:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one operation to the instance of latency lat and check it to completion
   task automatic do_op(input int lat, input logic ovf, input logic mr, input logic mw,
                        input logic m2r, input logic rw, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sdata, input string tag);
      int s;
      int cycles;
      logic [74:0] v;
      logic [37:0] exp;
      logic        expf;
      logic        legal;
      int unsigned idx;
      logic [31:0] old;
      s      = (lat == 2) ? 0 : 1;
      v      = {rw, mw, m2r, mr, ovf, 1'b0, rd, sdata, addr};
      idx    = addr >> 2;
      legal  = (addr[1:0] == 2'b00) && (idx < DEPTH) && !(mr && mw);
      cycles = 1;
      expf   = 1'b0;
      if (ovf) begin
         exp = {1'b0, rd, addr};
      end else if (!(mr || mw)) begin
         exp = {rw, rd, addr};
      end else if (!legal) begin
         exp  = {1'b0, rd, addr};
         expf = 1'b1;
      end else begin
         old = mdl[s][idx];
         if (mw) mdl[s][idx] = sdata;
         exp    = {rw, rd, m2r ? old : addr};
         cycles = lat;
      end
      if (s == 0) ex2 = v; else ex3 = v;
      for (int k = 1; k < cycles; k++) begin
         step();
         chk1({tag, ":stall"}, (s == 0) ? st2 : st3, 1'b1);
         chk38({tag, ":bubble"}, (s == 0) ? wb2 : wb3, {1'b0, last_wb[s][36:0]});
         chk1({tag, ":nofault_busy"}, (s == 0) ? ft2 : ft3, 1'b0);
      end
      step();
      chk38({tag, ":wb"}, (s == 0) ? wb2 : wb3, exp);
      chk1({tag, ":stall_done"}, (s == 0) ? st2 : st3, 1'b0);
      chk1({tag, ":fault"}, (s == 0) ? ft2 : ft3, expf);
      last_wb[s]     = exp;
      last_wb[1 - s] = '0;
      if (s == 0) ex2 = '0; else ex3 = '0;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      int          lat;
      int          kind;
      rst_n = 1'b0;
      ex2 = '0;
      ex3 = '0;
      last_wb[0] = '0;
      last_wb[1] = '0;
      repeat (2) @(negedge clk);
      chk38("rst:wb2", wb2, 38'd0);
      chk1("rst:st2", st2, 1'b0);
      chk1("rst:ft2", ft2, 1'b0);
      chk38("rst:wb3", wb3, 38'd0);
      chk1("rst:st3", st3, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Non-memory op
      do_op(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 32'd10, 32'd0, "alu");

      // Preload the low 32 words of each memory with values that are never 77 or 99
      for (int i = 0; i < 32; i++) begin
         d = $urandom | 32'h0001_0000;
         do_op(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'(i * 4), d, "pre2");
         d = $urandom | 32'h0001_0000;
         do_op(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'(i * 4), d, "pre3");
      end

      // Store then load back at L=2
      do_op(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd8, 32'd165, "st8");
      do_op(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'd8, 32'd0, "ld8");
      chk38("ld8:value", wb2, {1'b1, 5'd9, 32'd165});

      // Misaligned load, then index 1 is unchanged
      do_op(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'd6, 32'd0, "mis6");
      do_op(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'd4, 32'd0, "ld4");

      // Out-of-range store and read+write conflict, then memory unchanged
      do_op(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'(4 * DEPTH), 32'd55, "oor");
      do_op(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'd20, 32'd66, "rdwr");
      do_op(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'd20, 32'd0, "ld20");

      // Overflow-squashed store, then load returns the old value
      do_op(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'd12, 32'd99, "ovf");
      do_op(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'd12, 32'd0, "ld12");
      checks++;
      assert (wb2[31:0] !== 32'd99) else begin
         failures++;
         $error("FAIL ovf_not99 observed=%0d expected=not 99", wb2[31:0]);
      end

      // Store with RegWrite=1 reports the ALU result; last legal word boundary
      do_op(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'(4 * (DEPTH - 1)), 32'hCAFE_0001, "stlast");
      do_op(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'(4 * (DEPTH - 1)), 32'd0, "ldlast");

      // Reset in the middle of a 3-cycle store to addr 16
      ex3 = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'd77, 32'd16};
      step();
      chk1("rstmid:stall_before", st3, 1'b1);
      rst_n = 1'b0;
      #1;
      chk38("rstmid:wb3", wb3, 38'd0);
      chk1("rstmid:st3", st3, 1'b0);
      chk1("rstmid:ft3", ft3, 1'b0);
      chk38("rstmid:wb2", wb2, 38'd0);
      ex3 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      last_wb[0] = '0;
      last_wb[1] = '0;
      do_op(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'd16, 32'd0, "ld16");
      checks++;
      assert (wb3[31:0] !== 32'd77) else begin
         failures++;
         $error("FAIL rst_not77 observed=%0d expected=not 77", wb3[31:0]);
      end

      // Back-to-back loads at L=3
      do_op(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 32'd24, 32'd0, "b2b_a");
      do_op(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15, 32'd28, 32'd0, "b2b_b");

      // Randomized mix on both instances
      for (int n = 0; n < 80; n++) begin
         lat  = ($urandom_range(0, 1) == 0) ? 2 : 3;
         kind = $urandom_range(0, 9);
         a    = 32'($urandom_range(0, 31)) << 2;
         d    = $urandom;
         case (kind)
            0: do_op(lat, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, d, "r_alu");
            1: do_op(lat, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 5'($urandom), a, d, "r_ovf");
            2: do_op(lat, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'($urandom), a | 32'($urandom_range(1, 3)), d, "r_mis");
            3: do_op(lat, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'($urandom), 32'(4 * DEPTH) + (32'($urandom_range(0, 1000)) << 2), d, "r_oor");
            4: do_op(lat, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'($urandom), a, d, "r_rw");
            5, 6: do_op(lat, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 5'($urandom), a, d, "r_st");
            default: do_op(lat, 1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), a, d, "r_ld");
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
